// File: rtl/hop_lane_sequencer.sv
// hop_lane_sequencer
//   Controller for NUM_LANES parallel hop chains. Each chain is a DEPTH-flop
//   shift path with one reset per flop. The block:
//     - sequences the per-stage resets after reset, head stage first,
//     - round-robin arbitrates lane launch requests and drives chain starts,
//     - checks that every launched token reaches the chain tail exactly
//       DEPTH cycles after launch.
//
// Ports
//   clock0     in   1                 single clock, all logic on posedge
//   rst1       in   1                 synchronous, active-high reset
//   req        in   NUM_LANES         per-lane launch request (level)
//   lane_out   in   NUM_LANES         tail-flop output of each chain
//   grant      out  NUM_LANES         one-hot launch grant, 1-cycle pulse
//   start      out  NUM_LANES         chain start inputs, equal to grant
//   stage_rst  out  NUM_LANES*DEPTH   per-flop reset, bit l*DEPTH+s = lane l stage s
//   ready      out  1                 init sequence complete
//   done       out  NUM_LANES         1-cycle pulse: token arrived on time
//   err        out  NUM_LANES         sticky: token missing, cleared by rst1 only
//
// Request/grant protocol: req is a level, not a valid/ready handshake. A lane
// is launched in the cycle its grant bit is high; a requester that keeps req
// high after its grant asks for another launch. Requests are only considered
// once ready is high, and a lane with a token in flight is not eligible.
//
// Configuration macro HOP_PIPE_EN: when defined, each lane tracks arrivals
// with a DEPTH-bit expect shift register, so a lane is never busy and may
// have up to DEPTH tokens in flight. When undefined, one token per lane is
// tracked with a down-counter.

module hop_lane_sequencer #(
  parameter int NUM_LANES = 4,
  parameter int DEPTH     = 4,
  parameter int REL_GAP   = 2
) (
  input  logic                       clock0,
  input  logic                       rst1,
  input  logic [NUM_LANES-1:0]       req,
  input  logic [NUM_LANES-1:0]       lane_out,
  output logic [NUM_LANES-1:0]       grant,
  output logic [NUM_LANES-1:0]       start,
  output logic [NUM_LANES*DEPTH-1:0] stage_rst,
  output logic                       ready,
  output logic [NUM_LANES-1:0]       done,
  output logic [NUM_LANES-1:0]       err
);

  localparam int INIT_LEN = DEPTH + DEPTH * REL_GAP;
  localparam int TW       = $clog2(INIT_LEN + 1);
  localparam int PW       = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
  localparam int CW       = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {
    HOLD    = 2'd0,
    RELEASE = 2'd1,
    RUN     = 2'd2
  } state_t;

  state_t        state, state_nxt;
  logic [TW-1:0] timer, timer_nxt;

  // ---------------------------------------------------------------------
  // Init sequencer. timer equals the cycle number since reset release while
  // in HOLD/RELEASE, so stage release points are simple compares on it.
  // ---------------------------------------------------------------------
  always_ff @(posedge clock0) begin
    if (rst1) begin
      state <= HOLD;
      timer <= '0;
    end else begin
      state <= state_nxt;
      timer <= timer_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    timer_nxt = timer;
    stage_rst = '1;
    case (state)
      HOLD: begin
        timer_nxt = timer + TW'(1);
        if (int'(timer) == DEPTH - 1) state_nxt = RELEASE;
      end
      RELEASE: begin
        timer_nxt = timer + TW'(1);
        // Stage s is released from cycle DEPTH + s*REL_GAP onward.
        for (int s = 0; s < DEPTH; s++) begin
          if (int'(timer) >= DEPTH + s * REL_GAP) begin
            for (int l = 0; l < NUM_LANES; l++) stage_rst[l*DEPTH+s] = 1'b0;
          end
        end
        if (int'(timer) == INIT_LEN - 1) state_nxt = RUN;
      end
      RUN: begin
        stage_rst = '0;
      end
      default: begin
        state_nxt = HOLD;
      end
    endcase
    // All outputs show reset values while rst1 is held.
    if (rst1) stage_rst = '1;
  end

  logic run;
  assign run   = (state == RUN) && !rst1;
  assign ready = run;

  // ---------------------------------------------------------------------
  // Round-robin arbiter. The grant is decided in the launch cycle from the
  // registered pointer and busy state, so a request seen in cycle T is
  // granted in cycle T.
  // ---------------------------------------------------------------------
  logic [NUM_LANES-1:0] busy, sample, elig;
  logic [PW-1:0]        ptr, ptr_nxt, gidx;
  logic                 found;
  int                   idx;

  assign elig = req & ~busy & {NUM_LANES{run}};

  always_comb begin
    grant = '0;
    found = 1'b0;
    gidx  = '0;
    idx   = 0;
    for (int i = 0; i < NUM_LANES; i++) begin
      idx = (int'(ptr) + i) % NUM_LANES;
      if (!found && elig[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        gidx       = PW'(idx);
      end
    end
    ptr_nxt = (int'(gidx) == NUM_LANES - 1) ? '0 : gidx + PW'(1);
  end

  assign start = grant;

  always_ff @(posedge clock0) begin
    if (rst1)       ptr <= '0;
    else if (found) ptr <= ptr_nxt;
  end

  // ---------------------------------------------------------------------
  // Per-lane arrival tracking. sample[l] is high in the cycle DEPTH cycles
  // after a launch on lane l, when lane_out[l] must be 1.
  // ---------------------------------------------------------------------
  genvar gl;
  generate
    for (gl = 0; gl < NUM_LANES; gl++) begin : g_lane
`ifdef HOP_PIPE_EN
      logic [DEPTH-1:0] exp_sr;
      always_ff @(posedge clock0) begin
        if (rst1) exp_sr <= '0;
        else      exp_sr <= (exp_sr << 1) | DEPTH'(grant[gl]);
      end
      assign busy[gl]   = 1'b0;
      assign sample[gl] = exp_sr[DEPTH-1];
`else
      logic [CW-1:0] cnt;
      // Loads DEPTH on grant; reaches 1 in the sample cycle and 0 right
      // after, which frees the lane for the following cycle.
      always_ff @(posedge clock0) begin
        if (rst1)            cnt <= '0;
        else if (grant[gl])  cnt <= CW'(DEPTH);
        else if (cnt != '0)  cnt <= cnt - CW'(1);
      end
      assign busy[gl]   = (cnt != '0);
      assign sample[gl] = (cnt == CW'(1));
`endif
    end
  endgenerate

  always_ff @(posedge clock0) begin
    if (rst1) begin
      done <= '0;
      err  <= '0;
    end else begin
      done <= sample & lane_out;
      err  <= err | (sample & ~lane_out);
    end
  end

endmodule
